// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory master: RV32I funct3
// encodings, the controller state enum and the request legality check.
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_LOAD_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } lsu_state_t;

  // A request is an error when its funct3 is not a legal encoding for its
  // direction, or when the access is not naturally aligned to its size.
  function automatic logic lsu_req_error(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic err;
    err = 1'b1;
    if (we) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = offset[0];
        F3_SW:   err = |offset;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:   err = 1'b0;
        F3_LH:   err = offset[0];
        F3_LW:   err = |offset;
        F3_LBU:  err = 1'b0;
        F3_LHU:  err = offset[0];
        default: err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load data alignment: shifts the addressed byte/halfword of the
// RAM word down to bit 0 and applies sign or zero extension.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] mem_do,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Byte offset selects how far the word is shifted right.
  assign shifted = mem_do >> {offset, 3'b000};

  // Extend the low byte/halfword according to the load type; LW passes through.
  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'h000000, shifted[7:0]};
      F3_LHU:  result = {16'h0000, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: accepts one core request at a time, issues a
// single registered access to a byte-write RAM with one-cycle read latency,
// and returns a held response (extended load data or an error flag).
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [DATA_LENGTH-1:0]    req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_LENGTH-1:0]    resp_rdata,
  output logic                      resp_err,
  output logic                      MEM_EN,
  output logic [3:0]                MEM_WE,
  output logic [ADDRESS_LENGTH-1:0] MEM_A,
  output logic [DATA_LENGTH-1:0]    MEM_Di,
  input  logic [DATA_LENGTH-1:0]    MEM_Do
);

  localparam int NUM_LANES = DATA_LENGTH / 8;

  lsu_state_t state_reg, state_next;

  // Memory-side outputs are registers so the RAM sees clean, glitch-free
  // controls for the whole ACCESS cycle. MEM_Di doubles as the latched
  // store data, and MEM_A holds the latched word address.
  logic                      mem_en_reg, mem_en_next;
  logic [3:0]                mem_we_reg, mem_we_next;
  logic [ADDRESS_LENGTH-1:0] mem_a_reg, mem_a_next;
  logic [DATA_LENGTH-1:0]    mem_di_reg, mem_di_next;

  // Only the pieces of the request still needed after acceptance are kept:
  // direction, funct3 and the byte offset used by load extraction.
  logic                      we_reg, we_next;
  logic [2:0]                funct3_reg, funct3_next;
  logic [1:0]                offset_reg, offset_next;

  logic [DATA_LENGTH-1:0]    resp_rdata_reg, resp_rdata_next;
  logic                      resp_err_reg, resp_err_next;

  logic                      req_error;
  logic [DATA_LENGTH-1:0]    sb_data;
  logic [DATA_LENGTH-1:0]    sh_data;
  logic [DATA_LENGTH-1:0]    store_di;
  logic [3:0]                store_we;
  logic [31:0]               load_result;

  // Address bits above the RAM size are deliberately dropped (wrap-around).
  logic                      unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDRESS_LENGTH+2];

  assign req_error = lsu_req_error(req_we, req_funct3, req_addr[1:0]);

  // Replicate the store byte/halfword across all lanes; MEM_WE picks the lane.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign sb_data[8*gi +: 8] = req_wdata[7:0];
      assign sh_data[8*gi +: 8] = req_wdata[8*(gi % 2) +: 8];
    end
  endgenerate

  // Store lane data and byte enables for the incoming request.
  always_comb begin
    store_di = req_wdata;
    store_we = 4'b1111;
    case (req_funct3)
      F3_SB: begin
        store_di = sb_data;
        store_we = 4'b0001 << req_addr[1:0];
      end
      F3_SH: begin
        store_di = sh_data;
        store_we = 4'b0011 << req_addr[1:0];
      end
      default: begin
        store_di = req_wdata;
        store_we = 4'b1111;
      end
    endcase
  end

  lsu_load_extract u_load_extract (
    .mem_do (MEM_Do),
    .offset (offset_reg),
    .funct3 (funct3_reg),
    .result (load_result)
  );

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and next register values; memory enables default to idle so
  // they can only be asserted for the single cycle spent in ACCESS.
  always_comb begin
    state_next      = state_reg;
    mem_en_next     = 1'b0;
    mem_we_next     = 4'b0000;
    mem_a_next      = mem_a_reg;
    mem_di_next     = mem_di_reg;
    we_next         = we_reg;
    funct3_next     = funct3_reg;
    offset_next     = offset_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          we_next     = req_we;
          funct3_next = req_funct3;
          offset_next = req_addr[1:0];
          if (req_error) begin
            // Illegal requests answer immediately and never touch the RAM.
            state_next      = ST_RESP;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else begin
            state_next    = ST_ACCESS;
            resp_err_next = 1'b0;
            mem_en_next   = 1'b1;
            mem_a_next    = req_addr[ADDRESS_LENGTH+1:2];
            if (req_we) begin
              mem_di_next = store_di;
              mem_we_next = store_we;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (we_reg) begin
          state_next      = ST_RESP;
          resp_rdata_next = '0;
        end else begin
          state_next = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        // RAM data is only valid this one cycle; it reads zero once EN drops.
        resp_rdata_next = load_result;
        state_next      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 4'b0000;
      mem_a_reg      <= '0;
      mem_di_reg     <= '0;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      offset_reg     <= 2'b00;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_a_reg      <= mem_a_next;
      mem_di_reg     <= mem_di_next;
      we_reg         <= we_next;
      funct3_reg     <= funct3_next;
      offset_reg     <= offset_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign MEM_EN     = mem_en_reg;
  assign MEM_WE     = mem_we_reg;
  assign MEM_A      = mem_a_reg;
  assign MEM_Di     = mem_di_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: a byte-write RAM with registered read, a
// byte-array reference memory, and directed plus random load/store traffic.
module tb_lsu_mem_master;

  localparam int AL        = 11;
  localparam int MEM_WORDS = 1 << AL;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          MEM_EN;
  logic [3:0]    MEM_WE;
  logic [AL-1:0] MEM_A;
  logic [31:0]   MEM_Di;
  logic [31:0]   MEM_Do;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  lsu_mem_master #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .MEM_EN     (MEM_EN),
    .MEM_WE     (MEM_WE),
    .MEM_A      (MEM_A),
    .MEM_Di     (MEM_Di),
    .MEM_Do     (MEM_Do)
  );

  // RAM: byte writes, one-cycle registered read, output zero when not enabled.
  logic [31:0] ram [0:MEM_WORDS-1] = '{default: '0};
  always @(posedge CLK) begin
    if (MEM_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (MEM_WE[b]) ram[MEM_A][8*b +: 8] <= MEM_Di[8*b +: 8];
      end
      MEM_Do <= ram[MEM_A];
    end else begin
      MEM_Do <= '0;
    end
  end

  // Reference memory, little-endian bytes, updated per accepted store.
  logic [7:0] ref_mem [0:MEM_BYTES-1] = '{default: '0};

  // Memory-bus monitor: counts enabled cycles, records the last access, and
  // counts any write enable seen while the RAM is not enabled.
  int            en_cycles = 0;
  int            stray     = 0;
  logic [3:0]    cap_we    = '0;
  logic [AL-1:0] cap_a     = '0;
  logic [31:0]   cap_di    = '0;
  always @(negedge CLK) begin
    if (MEM_EN) begin
      en_cycles <= en_cycles + 1;
      cap_we    <= MEM_WE;
      cap_a     <= MEM_A;
      cap_di    <= MEM_Di;
    end else if (MEM_WE != 4'b0000) begin
      stray <= stray + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal_req(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit f3_ok;
    if (we) f3_ok = (f3 inside {3'd0, 3'd1, 3'd2});
    else    f3_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!f3_ok) return 1'b0;
    return (addr[1:0] & 2'(size_of(f3) - 1)) == 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    int base;
    v    = '0;
    sz   = size_of(f3);
    base = int'(addr[AL+1:0]);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + i];
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic drive_junk();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One full transaction, called and returning at a negedge in IDLE.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] got_rdata, output logic got_err);
    bit          legal;
    int          sz;
    int          base;
    int          en0;
    int          lat;
    int          waitn;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_di;

    legal     = legal_req(we, f3, addr);
    sz        = size_of(f3);
    base      = int'(addr[AL+1:0]);
    exp_rdata = '0;
    exp_we    = 4'b0000;
    exp_di    = '0;
    if (legal && we) begin
      exp_we = 4'(((1 << sz) - 1) << addr[1:0]);
      for (int k = 0; k < 4; k++) exp_di[8*k +: 8] = wdata[8*(k % sz) +: 8];
      for (int i = 0; i < sz; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else if (legal) begin
      exp_rdata = model_load(f3, addr);
    end
    exp_lat   = !legal ? 1 : (we ? 2 : 3);
    got_rdata = '0;
    got_err   = 1'b0;

    waitn = 0;
    while (!req_ready && waitn < 20) begin
      @(negedge CLK);
      waitn++;
    end
    if (!req_ready) begin
      check_eq("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      return;
    end

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    en0        = en_cycles;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    drive_junk();
    while (!resp_valid && lat < 8) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      drive_junk();
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    got_rdata = resp_rdata;
    got_err   = resp_err;
    check_eq("resp_err", {31'b0, resp_err}, {31'b0, !legal});
    check_eq("resp_rdata", resp_rdata, exp_rdata);
    check_eq("mem_en_cycles", 32'(en_cycles - en0), legal ? 32'd1 : 32'd0);
    if (legal) begin
      check_eq("mem_a", 32'(cap_a), 32'(addr[AL+1:2]));
      check_eq("mem_we", 32'(cap_we), 32'(exp_we));
      if (we) check_eq("mem_di", cap_di, exp_di);
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      @(negedge CLK);
      drive_junk();
      check_eq("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("stall_rdata", resp_rdata, exp_rdata);
      check_eq("stall_err", {31'b0, resp_err}, {31'b0, !legal});
      check_eq("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end

    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    resp_ready = 1'b0;
    check_eq("ready_after_hs", {31'b0, req_ready}, 32'd1);
    check_eq("valid_after_hs", {31'b0, resp_valid}, 32'd0);
    $display("txn we=%0d f3=%0d addr=%08h wdata=%08h hold=%0d -> rdata=%08h err=%0d lat=%0d",
             we, f3, addr, wdata, hold, got_rdata, got_err, lat);
  endtask

  logic [31:0] r;
  logic        e;
  int          bad_words;

  initial begin
    RST        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    // Reset state
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_mem_en", {31'b0, MEM_EN}, 32'd0);
    check_eq("rst_mem_we", 32'(MEM_WE), 32'd0);
    check_eq("rst_mem_a", 32'(MEM_A), 32'd0);
    check_eq("rst_mem_di", MEM_Di, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", {31'b0, resp_err}, 32'd0);

    // Word store
    do_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, r, e);
    check_eq("sw_mem_a", 32'(cap_a), 32'd4);
    check_eq("sw_mem_we", 32'(cap_we), 32'hF);
    check_eq("sw_mem_di", cap_di, 32'hDEAD_BEEF);
    check_eq("sw_err", {31'b0, e}, 32'd0);

    // Byte store into the top lane, then word readback
    do_txn(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1, r, e);
    check_eq("sb_mem_we", 32'(cap_we), 32'h8);
    check_eq("sb_mem_di", cap_di, 32'hA5A5_A5A5);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, r, e);
    check_eq("lw_after_sb", r, 32'hA5AD_BEEF);

    // Sub-word loads with extension
    do_txn(1'b0, 3'b000, 32'h13, 32'h0, 0, r, e);
    check_eq("lb_0x13", r, 32'hFFFF_FFA5);
    do_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, r, e);
    check_eq("lbu_0x13", r, 32'h0000_00A5);
    do_txn(1'b0, 3'b001, 32'h12, 32'h0, 0, r, e);
    check_eq("lh_0x12", r, 32'hFFFF_A5AD);

    // Misaligned requests are rejected without touching memory
    do_txn(1'b0, 3'b010, 32'h11, 32'h0, 0, r, e);
    check_eq("lw_misaligned_err", {31'b0, e}, 32'd1);
    do_txn(1'b1, 3'b001, 32'h13, 32'h1234_5678, 0, r, e);
    check_eq("sh_misaligned_err", {31'b0, e}, 32'd1);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 5, r, e);
    check_eq("lw_after_errors", r, 32'hA5AD_BEEF);

    // Reset while the load waits for RAM data
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    check_eq("abort_access_en", {31'b0, MEM_EN}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_loadwait_en", {31'b0, MEM_EN}, 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_eq("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("abort_mem_en", {31'b0, MEM_EN}, 32'd0);
    check_eq("abort_mem_we", 32'(MEM_WE), 32'd0);
    check_eq("abort_req_ready", {31'b0, req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_eq("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    end

    // Random traffic, clustered in a small window so loads see earlier stores;
    // random upper address bits exercise wrap-around.
    for (int t = 0; t < 200; t++) begin
      logic [2:0]  f3;
      logic        we;
      logic [31:0] addr;
      we = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else    f3 = 3'(($urandom_range(0, 4) + 32'd1) % 6);
      end else begin
        f3 = 3'($urandom);
      end
      if ($urandom_range(0, 3) == 0) addr = $urandom;
      else addr = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 63));
      do_txn(we, f3, addr, $urandom, $urandom_range(0, 3), r, e);
    end

    bad_words = 0;
    for (int w = 0; w < MEM_WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (ram[w][8*b +: 8] !== ref_mem[4*w + b]) bad_words++;
      end
    end
    check_eq("mem_image_bad_bytes", 32'(bad_words), 32'd0);
    check_eq("stray_we_cycles", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter ADDRESS_LENGTH, default 11, word-address width of the attached byte-write data RAM.
REQ-002 SHALL have parameter DATA_LENGTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have one clock and a synchronous active-high reset: CLK in 1, rising-edge clock for all state; RST in 1, synchronous active-high reset.
REQ-004 SHALL have port: req_valid in 1, core request strobe.
REQ-005 SHALL have port: req_ready out 1, high only in IDLE.
REQ-006 SHALL have port: req_we in 1, 1=store, 0=load.
REQ-007 SHALL have port: req_funct3 in 3, RV32I load/store funct3.
REQ-008 SHALL have port: req_addr in 32, byte address.
REQ-009 SHALL have port: req_wdata in 32, store data, right-aligned.
REQ-010 SHALL have port: resp_valid out 1, response strobe.
REQ-011 SHALL have port: resp_ready in 1, core accepts response.
REQ-012 SHALL have port: resp_rdata out 32, extended load data; 0 for stores and errors.
REQ-013 SHALL have port: resp_err out 1, misaligned access or illegal funct3.
REQ-014 SHALL have memory-side ports: MEM_EN out 1, MEM_WE out 4, MEM_A out ADDRESS_LENGTH, MEM_Di out 32, MEM_Do in 32.

Function
REQ-015 SHALL be an FSM with states IDLE, ACCESS, LOAD_WAIT and RESP.
REQ-016 SHALL latch addr, funct3, we and wdata on req_valid && req_ready.
REQ-017 SHALL classify the request at acceptance: halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 outside {000,001,010,100,101} for loads or {000,001,010} for stores -> error; an error goes IDLE->RESP with resp_err=1 and makes no memory access.
REQ-018 SHALL take a legal request IDLE->ACCESS.
REQ-019 SHALL drive MEM_EN=1 only in ACCESS, registered outputs; MEM_WE SHALL be 0000 in every other state, so there are no stray writes.
REQ-020 SHALL set MEM_A = latched addr[ADDRESS_LENGTH+1:2]; upper address bits are ignored, so the address wraps modulo RAM size.
REQ-021 SHALL form the store lanes as follows: SB MEM_Di={4{byte}}, MEM_WE=0001<<addr[1:0]; SH MEM_Di={2{half}}, MEM_WE=0011<<addr[1:0]; SW MEM_Di=wdata, MEM_WE=1111.
REQ-022 SHALL drive MEM_WE=0000 in ACCESS for loads.
REQ-023 SHALL route a store ACCESS->RESP and a load ACCESS->LOAD_WAIT.
REQ-024 SHALL capture MEM_Do in LOAD_WAIT, the cycle after ACCESS, because the RAM returns zero once EN drops; LOAD_WAIT->RESP.
REQ-025 SHALL extract load data as Do>>(8*addr[1:0]): LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-026 SHALL hold resp_valid=1 and resp_rdata/resp_err stable in RESP until resp_ready=1, then go RESP->IDLE.
REQ-027 SHALL keep req_ready=0 in RESP; the next request is accepted one cycle after the response handshake.
REQ-028 SHALL have fixed latency from the acceptance edge to resp_valid: load 3 cycles, store 2, error 1.
REQ-029 SHALL ignore req_valid outside IDLE; the request fields may change freely there.

Reset
REQ-030 SHALL on RST=1 at an edge go to IDLE with MEM_EN=0, MEM_WE=0000, MEM_A=0, MEM_Di=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after release.
REQ-031 SHALL abort any in-flight request on reset mid-operation with no response; a store already issued in ACCESS is not undone.

Structure
REQ-032 SHALL keep the funct3 constants (LB..LHU, SB..SW) and the state enum in shared package lsu_pkg.
REQ-033 SHALL place the combinational load extraction and sign extension in sub-module lsu_load_extract (in: Do, offset, funct3; out: 32-bit result).

Verification
REQ-034 SHALL cover this scenario: SW addr 0x10, data 0xDEADBEEF -> ACCESS MEM_A=4, MEM_WE=1111, MEM_Di=0xDEADBEEF; resp_valid 2 cycles after acceptance, err=0.
REQ-035 SHALL cover this scenario: SB addr 0x13, data 0x000000A5 -> MEM_WE=1000, MEM_Di=0xA5A5A5A5; a following LW 0x10 returns 0xA5ADBEEF.
REQ-036 SHALL cover this scenario: LB 0x13 -> resp_rdata 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LH 0x12 -> 0xFFFFA5AD; latency 3.
REQ-037 SHALL cover this scenario: LW 0x11 and SH 0x13 -> resp_err=1 after 1 cycle, MEM_EN never asserted, memory unchanged.
REQ-038 SHALL cover this scenario: resp_ready held low 5 cycles -> resp_valid and data stable, req_ready=0 throughout; new request accepted the cycle after the handshake.
REQ-039 SHALL cover this scenario: RST asserted in LOAD_WAIT -> next cycle IDLE, resp_valid=0, MEM_EN=0, no response delivered.
